// File: rtl/routing_ctrl_pio_ext.sv
// Avalon-MM parallel I/O slave: output register with set/clear aliases, synchronised
// input port with edge capture and a maskable level interrupt. Read latency is one cycle.
module routing_ctrl_pio_ext #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    IN_WIDTH    = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                    EDGE_TYPE   = 0,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic                  read_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [IN_WIDTH-1:0]   in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 1);

  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_reg, data_next;
  logic [IN_WIDTH-1:0]   mask_reg, mask_next;
  logic [IN_WIDTH-1:0]   cap_reg, cap_next;
  logic [IN_WIDTH-1:0]   cap_clr;
  logic [IN_WIDTH-1:0]   sync_reg [SYNC_STAGES];
  logic [IN_WIDTH-1:0]   prev_reg;
  logic [IN_WIDTH-1:0]   sync_val;
  logic [IN_WIDTH-1:0]   edge_raw;
  logic [IN_WIDTH-1:0]   edge_det;
  logic [2:0]            warm_reg;
  logic                  warm_done;
  logic [31:0]           readdata_reg, readdata_next;
  logic [31:0]           rd_mux;
  logic                  unused_writedata;

  assign wr_en            = chipselect & ~write_n;
  assign rd_en            = chipselect & ~read_n;
  assign sync_val         = sync_reg[SYNC_STAGES-1];
  assign warm_done        = (warm_reg == WARM_DONE);
  assign unused_writedata = ^writedata;

  // Synchroniser chain: stage 0 samples the pin, each later stage samples its predecessor.
  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) sync_reg[gi] <= '0;
          else          sync_reg[gi] <= in_port;
        end
      end else begin : g_next
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) sync_reg[gi] <= '0;
          else          sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign edge_raw = sync_val & ~prev_reg;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign edge_raw = ~sync_val & prev_reg;
    end else begin : g_any
      assign edge_raw = sync_val ^ prev_reg;
    end
  endgenerate

  // Inputs already active at reset release would otherwise look like fresh edges.
  assign edge_det = warm_done ? edge_raw : '0;

  always_comb begin
    data_next = data_reg;
    mask_next = mask_reg;
    cap_clr   = '0;
    if (wr_en) begin
      case (address)
        3'd0:    data_next = writedata[DATA_WIDTH-1:0];
        3'd2:    data_next = data_reg | writedata[DATA_WIDTH-1:0];
        3'd3:    data_next = data_reg & ~writedata[DATA_WIDTH-1:0];
        3'd4:    cap_clr   = writedata[IN_WIDTH-1:0];
        3'd5:    mask_next = writedata[IN_WIDTH-1:0];
        default: ;
      endcase
    end
    // A new edge takes precedence over a simultaneous clear of the same bit.
    cap_next = (cap_reg & ~cap_clr) | edge_det;
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      3'd0:    rd_mux[DATA_WIDTH-1:0] = data_reg;
      3'd1:    rd_mux[IN_WIDTH-1:0]   = sync_val;
      3'd4:    rd_mux[IN_WIDTH-1:0]   = cap_reg;
      3'd5:    rd_mux[IN_WIDTH-1:0]   = mask_reg;
      default: rd_mux = '0;
    endcase
    readdata_next = rd_en ? rd_mux : readdata_reg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg     <= RESET_VALUE;
      mask_reg     <= '0;
      cap_reg      <= '0;
      prev_reg     <= '0;
      warm_reg     <= '0;
      readdata_reg <= '0;
    end else begin
      data_reg     <= data_next;
      mask_reg     <= mask_next;
      cap_reg      <= cap_next;
      prev_reg     <= sync_val;
      readdata_reg <= readdata_next;
      if (!warm_done) warm_reg <= warm_reg + 3'd1;
    end
  end

  assign out_port = data_reg;
  assign readdata = readdata_reg;
  assign irq      = |(cap_reg & mask_reg);

endmodule

// File: tb/tb_routing_ctrl_pio_ext.sv
// Bench for routing_ctrl_pio_ext: a history-based model checks instance A every cycle,
// directed literal checks pin the model and cover an 8-bit any-edge instance B.
module tb_routing_ctrl_pio_ext;

  localparam int S  = 2;
  localparam int SB = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        cs_a = 1'b0, cs_b = 1'b0;
  logic        write_n = 1'b1, read_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] rd_a, rd_b;
  logic [31:0] in_a = '0;
  logic [7:0]  in_b = '0;
  logic [31:0] out_a;
  logic [7:0]  out_b;
  logic        irq_a, irq_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  routing_ctrl_pio_ext #(
    .DATA_WIDTH(32), .IN_WIDTH(32), .RESET_VALUE(32'hA5A5_0000),
    .EDGE_TYPE(0), .SYNC_STAGES(S)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_a),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(rd_a),
    .in_port(in_a), .out_port(out_a), .irq(irq_a)
  );

  routing_ctrl_pio_ext #(
    .DATA_WIDTH(8), .IN_WIDTH(8), .RESET_VALUE(8'h3C),
    .EDGE_TYPE(2), .SYNC_STAGES(SB)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_b),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(rd_b),
    .in_port(in_b), .out_port(out_b), .irq(irq_b)
  );

  // ---------------- behavioural model of instance A ----------------
  logic [31:0] m_data, m_mask, m_cap, m_rd;
  logic [31:0] hist[$];
  int          n_edges;

  function automatic logic [31:0] sync_after(int m);
    if (m < S) return 32'h0;
    return hist[m-S];
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_data  = 32'hA5A5_0000;
        m_mask  = '0;
        m_cap   = '0;
        m_rd    = '0;
        n_edges = 0;
        hist.delete();
      end else begin
        logic [31:0] s, p, edges, clr;
        n_edges++;
        s     = sync_after(n_edges - 1);
        p     = sync_after(n_edges - 2);
        edges = (n_edges >= S + 2) ? (s & ~p) : 32'h0;
        clr   = '0;
        if (cs_a && !read_n) begin
          case (address)
            3'd0:    m_rd = m_data;
            3'd1:    m_rd = s;
            3'd4:    m_rd = m_cap;
            3'd5:    m_rd = m_mask;
            default: m_rd = 32'h0;
          endcase
        end
        if (cs_a && !write_n) begin
          case (address)
            3'd0:    m_data = writedata;
            3'd2:    m_data = m_data | writedata;
            3'd3:    m_data = m_data & ~writedata;
            3'd4:    clr = writedata;
            3'd5:    m_mask = writedata;
            default: ;
          endcase
        end
        m_cap = (m_cap & ~clr) | edges;
        hist.push_back(in_a);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Per-cycle comparison of instance A against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        check("model_out_port", out_a, m_data);
        check("model_readdata", rd_a, m_rd);
        check("model_irq", {31'b0, irq_a}, {31'b0, |(m_cap & m_mask)});
      end
    end
  end

  // ---------------- bus tasks (called at a negedge) ----------------
  task automatic bus_wr(input bit b, input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; write_n = 1'b0; read_n = 1'b1;
    cs_a = !b; cs_b = b;
    @(negedge clk);
    cs_a = 1'b0; cs_b = 1'b0; write_n = 1'b1;
    $display("[TB] %s write addr=%0d data=%h", b ? "B" : "A", a, d);
  endtask

  task automatic bus_rd(input bit b, input logic [2:0] a, output logic [31:0] d);
    address = a; read_n = 1'b0; write_n = 1'b1;
    cs_a = !b; cs_b = b;
    @(negedge clk);
    d = b ? rd_b : rd_a;
    cs_a = 1'b0; cs_b = 1'b0; read_n = 1'b1;
    $display("[TB] %s read  addr=%0d data=%h", b ? "B" : "A", a, d);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] r;

  initial begin
    in_a = 32'hFFFF_FFFF;
    idle(3);
    #1;
    check("reset_out_a", out_a, 32'hA5A5_0000);
    check("reset_rd_a", rd_a, 32'h0);
    check("reset_irq_a", {31'b0, irq_a}, 32'h0);
    check("reset_out_b", {24'b0, out_b}, 32'h3C);
    @(negedge clk);
    reset_n = 1'b1;
    idle(6);

    // Input held high through reset release must not capture.
    bus_rd(0, 3'd4, r); check("warmup_edgecap", r, 32'h0);
    bus_rd(0, 3'd1, r); check("warmup_input", r, 32'hFFFF_FFFF);
    bus_rd(0, 3'd0, r); check("read_data_reset", r, 32'hA5A5_0000);

    in_a = 32'h0;
    idle(5);
    bus_rd(0, 3'd4, r); check("falling_ignored", r, 32'h0);

    // DATA / SET / CLEAR back to back.
    bus_wr(0, 3'd0, 32'h0000_00F0);
    bus_wr(0, 3'd2, 32'h0000_000F);
    bus_wr(0, 3'd3, 32'h0000_0030);
    check("set_clear_out", out_a, 32'h0000_00CF);
    bus_rd(0, 3'd2, r); check("read_set_zero", r, 32'h0);
    bus_rd(0, 3'd3, r); check("read_clr_zero", r, 32'h0);
    bus_wr(0, 3'd2, 32'h0);
    check("set_zero_nochange", out_a, 32'h0000_00CF);

    // Rising edge latency: irq exactly S+1 cycles after in_port changes.
    bus_wr(0, 3'd5, 32'h1);
    in_a = 32'h1;
    idle(S);
    check("irq_before_latency", {31'b0, irq_a}, 32'h0);
    idle(1);
    check("irq_at_latency", {31'b0, irq_a}, 32'h1);
    bus_rd(0, 3'd4, r); check("edgecap_set", r, 32'h1);
    bus_wr(0, 3'd4, 32'h1);
    check("irq_after_w1c", {31'b0, irq_a}, 32'h0);
    bus_rd(0, 3'd4, r); check("edgecap_cleared", r, 32'h0);

    // Edge and W1C in the same cycle: the set wins.
    in_a = 32'h0; idle(4);
    in_a = 32'h1; idle(4);
    in_a = 32'h0; idle(4);
    in_a = 32'h1; idle(S);
    bus_wr(0, 3'd4, 32'h1);
    check("collide_irq", {31'b0, irq_a}, 32'h1);
    bus_rd(0, 3'd4, r); check("collide_edgecap", r, 32'h1);

    bus_wr(0, 3'd5, 32'h0);
    check("mask_off_irq", {31'b0, irq_a}, 32'h0);
    bus_wr(0, 3'd5, 32'h1);
    check("mask_on_irq", {31'b0, irq_a}, 32'h1);

    // Asynchronous reset mid-operation.
    bus_rd(0, 3'd4, r);
    #3 reset_n = 1'b0;
    #1;
    check("async_out_a", out_a, 32'hA5A5_0000);
    check("async_rd_a", rd_a, 32'h0);
    check("async_irq_a", {31'b0, irq_a}, 32'h0);
    @(negedge clk);
    in_a = 32'h0;
    reset_n = 1'b1;
    idle(6);

    // Instance B: 8-bit data, any-edge capture, three sync stages.
    bus_wr(1, 3'd0, 32'hFFFF_FFFF);
    check("b_out_trunc", {24'b0, out_b}, 32'h0000_00FF);
    bus_rd(1, 3'd0, r); check("b_read_trunc", r, 32'h0000_00FF);
    bus_wr(1, 3'd6, 32'h0000_0000);
    check("b_reserved_wr", {24'b0, out_b}, 32'h0000_00FF);
    bus_rd(1, 3'd6, r); check("b_reserved_rd", r, 32'h0);
    bus_wr(1, 3'd5, 32'hFFFF_FF01);
    bus_rd(1, 3'd5, r); check("b_mask_trunc", r, 32'h0000_0001);
    in_b = 8'h01;
    idle(SB);
    check("b_irq_before", {31'b0, irq_b}, 32'h0);
    idle(1);
    check("b_irq_rise", {31'b0, irq_b}, 32'h1);
    bus_wr(1, 3'd4, 32'h1);
    check("b_irq_w1c", {31'b0, irq_b}, 32'h0);
    in_b = 8'h00;
    idle(SB + 1);
    check("b_irq_fall", {31'b0, irq_b}, 32'h1);
    bus_rd(1, 3'd4, r); check("b_edgecap", r, 32'h1);
    bus_rd(1, 3'd1, r); check("b_input", r, 32'h0);

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
